// File: rtl/decode_ctrl.sv
// decode_ctrl: MVB receive control. Oversamples the line at 16 clk/bit and
// resynchronises on every edge. It finds the master or slave start delimiter,
// Manchester-decodes 16-bit words, checks the CRC-7 + parity field after
// every group of up to 4 words, then verifies the NL end delimiter.
// Optional macro DECODE_CRC_CHECK_EN: when defined, the check field is
// compared. When undefined, the field is still consumed and Manchester-checked,
// and crc_ok always reads 1.
module decode_ctrl #(
  parameter logic [17:0] MASTER_SD = 18'b10_11_00_01_11_00_01_01_01,
  parameter logic [17:0] SLAVE_SD  = 18'b10_10_10_00_11_10_00_11_10,
  parameter int          MAX_WORDS = 16,
  parameter int          IDLE_CLKS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_in,
  input  logic [6:0]  slave_words,
  output logic        decode_over,
  output logic        frame_start,
  output logic [1:0]  frame_type,
  output logic [15:0] word_data,
  output logic        word_valid,
  output logic [6:0]  word_count,
  output logic        crc_valid,
  output logic        crc_ok,
  output logic        frame_over,
  output logic        frame_err,
  output logic [2:0]  err_code
);

  localparam int            IW        = $clog2(IDLE_CLKS + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CLKS - 1);
  localparam logic [6:0]    CRC_POLY  = 7'h65;  // x^7+x^6+x^5+x^2+1

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CHECK, S_END, S_DONE, S_ERROR
  } state_t;

  state_t r_state, w_state_nx;

  logic [1:0]    r_sync;
  logic          r_prev;
  logic [2:0]    r_phase;
  logic [IW-1:0] r_idle;
  logic [16:0]   r_win;
  logic          r_hsel, r_h0, r_act;
  logic [3:0]    r_bitcnt;
  logic [14:0]   r_shift;
  logic [6:0]    r_crc, r_chk, r_exp;
  logic          r_par;

  logic          w_line, w_edge, w_samp, w_idle_to;
  logic [17:0]   w_win_nx;
  logic          w_mmatch, w_smatch, w_sw_ok;
  logic          w_hb_done, w_pair_ok, w_bit, w_sym, w_fb;
  logic [6:0]    w_crc_nx, w_cnt_nx;
  logic [7:0]    w_rx_field, w_exp_field;
  logic          w_cmp_ok;
  logic          w_start, w_wvld, w_cvld, w_cok, w_err;
  logic [1:0]    w_ftype;
  logic [2:0]    w_ecode;

  assign w_line    = r_sync[1];
  assign w_edge    = w_line ^ r_prev;
  assign w_samp    = (r_phase == 3'd4);
  assign w_idle_to = (r_idle == IDLE_LAST) && !w_edge;
  assign w_win_nx  = {r_win, w_line};
  assign w_mmatch  = w_samp && (w_win_nx == MASTER_SD);
  assign w_smatch  = w_samp && (w_win_nx == SLAVE_SD);
  assign w_sw_ok   = ((slave_words == 7'd1) || (slave_words == 7'd2) ||
                      (slave_words == 7'd4) || (slave_words == 7'd8) ||
                      (slave_words == 7'd16)) && (int'(slave_words) <= MAX_WORDS);

  // Second half of a bit-time: the pair 10 is a 1 and the pair 01 is a 0.
  assign w_hb_done = w_samp && r_hsel;
  assign w_pair_ok = r_h0 ^ w_line;
  assign w_bit     = r_h0;
  assign w_sym     = w_hb_done && w_pair_ok;
  assign w_cnt_nx  = word_count + 7'd1;

  assign w_fb        = w_bit ^ r_crc[6];
  assign w_crc_nx    = {r_crc[5:0], 1'b0} ^ (w_fb ? CRC_POLY : 7'h00);
  assign w_rx_field  = {r_chk, w_bit};
  assign w_exp_field = {r_crc, r_par ^ (^r_crc)};
  assign w_cmp_ok    = (w_rx_field == w_exp_field);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // Next state and per-clock event strobes
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_ftype    = frame_type;
    w_wvld     = 1'b0;
    w_cvld     = 1'b0;
    w_cok      = 1'b0;
    w_err      = 1'b0;
    w_ecode    = 3'd0;
`ifdef DECODE_CRC_CHECK_EN
    w_cok = w_cmp_ok;
`else
    // The comparison is still formed; only its result is overridden.
    w_cok = w_cmp_ok | 1'b1;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_mmatch) begin
          w_start    = 1'b1;
          w_ftype    = 2'b01;
          w_state_nx = S_DATA;
        end else if (w_smatch) begin
          w_start = 1'b1;
          w_ftype = 2'b10;
          if (w_sw_ok) w_state_nx = S_DATA;
          else begin w_state_nx = S_ERROR; w_err = 1'b1; w_ecode = 3'd5; end
        end
      end
      // A 00/11 pair counts as a violation only if the line moved during it.
      // A completely quiet bit-time is silence and is left to the timeout.
      S_DATA: begin
        if (w_idle_to) begin
          w_state_nx = S_ERROR; w_err = 1'b1; w_ecode = 3'd4;
        end else if (w_hb_done) begin
          if (w_pair_ok) begin
            if (r_bitcnt == 4'd15) begin
              w_wvld = 1'b1;
              if ((w_cnt_nx[1:0] == 2'b00) || (w_cnt_nx == r_exp)) w_state_nx = S_CHECK;
            end
          end else if (r_act || w_edge) begin
            w_state_nx = S_ERROR; w_err = 1'b1; w_ecode = 3'd1;
          end
        end
      end
      S_CHECK: begin
        if (w_idle_to) begin
          w_state_nx = S_ERROR; w_err = 1'b1; w_ecode = 3'd4;
        end else if (w_hb_done) begin
          if (w_pair_ok) begin
            if (r_bitcnt == 4'd7) begin
              w_cvld = 1'b1;
              if (!w_cok) begin
                w_state_nx = S_ERROR; w_err = 1'b1; w_ecode = 3'd2;
              end else begin
                w_state_nx = (word_count == r_exp) ? S_END : S_DATA;
              end
            end
          end else if (r_act || w_edge) begin
            w_state_nx = S_ERROR; w_err = 1'b1; w_ecode = 3'd1;
          end
        end
      end
      S_END: begin
        if (w_idle_to) begin
          w_state_nx = S_ERROR; w_err = 1'b1; w_ecode = 3'd4;
        end else if (w_hb_done) begin
          if (!r_h0 && !w_line) w_state_nx = S_DONE;
          else begin w_state_nx = S_ERROR; w_err = 1'b1; w_ecode = 3'd3; end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      S_ERROR: if (w_idle_to) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Line sampling, bit assembly, CRC accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync      <= '0;
      r_prev      <= 1'b0;
      r_phase     <= '0;
      r_idle      <= '0;
      r_win       <= '0;
      r_hsel      <= 1'b0;
      r_h0        <= 1'b0;
      r_act       <= 1'b0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_crc       <= '0;
      r_chk       <= '0;
      r_par       <= 1'b0;
      r_exp       <= '0;
      decode_over <= 1'b0;
      frame_start <= 1'b0;
      frame_type  <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      word_count  <= '0;
      crc_valid   <= 1'b0;
      crc_ok      <= 1'b0;
      frame_over  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
    end else begin
      r_sync  <= {r_sync[0], line_in};
      r_prev  <= r_sync[1];
      r_phase <= w_edge ? 3'd0 : r_phase + 3'd1;
      // Quiet-time counter; restarted on entering ERROR so that the wait is
      // always a full quiet period.
      if (w_edge || w_err)          r_idle <= '0;
      else if (r_idle != IDLE_LAST) r_idle <= r_idle + IW'(1);

      frame_start <= w_start;
      frame_type  <= w_ftype;
      word_valid  <= w_wvld;
      crc_valid   <= w_cvld;
      crc_ok      <= w_cvld & w_cok;
      frame_over  <= (w_state_nx == S_DONE);
      frame_err   <= w_err;
      decode_over <= (w_state_nx != S_IDLE);
      if (w_err) err_code <= w_ecode;

      if (w_start) begin
        word_count <= '0;
        r_exp      <= w_mmatch ? 7'd1 : slave_words;
      end
      if (w_wvld) begin
        word_data  <= {r_shift, w_bit};
        word_count <= w_cnt_nx;
      end

      if (w_state_nx != S_IDLE) r_win <= '0;
      else if (w_samp)          r_win <= w_win_nx[16:0];

      if (w_samp) begin
        r_hsel <= ~r_hsel;
        if (!r_hsel) r_h0 <= w_line;
      end
      if (w_hb_done)   r_act <= 1'b0;
      else if (w_edge) r_act <= 1'b1;
      if (w_sym) begin
        r_bitcnt <= r_bitcnt + 4'd1;
        r_shift  <= {r_shift[13:0], w_bit};
      end

      // The CRC and parity restart at every group start.
      if ((r_state != S_DATA) && (w_state_nx == S_DATA)) begin
        r_crc <= '0;
        r_par <= 1'b0;
      end else if (w_sym && (r_state == S_DATA)) begin
        r_crc <= w_crc_nx;
        r_par <= r_par ^ w_bit;
      end
      if (w_sym && (r_state == S_CHECK)) r_chk <= {r_chk[5:0], w_bit};

      if (w_state_nx != r_state) begin
        r_hsel   <= 1'b0;
        r_bitcnt <= '0;
        r_act    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: drives Manchester frames into decode_ctrl. It queues the
// expected output events before each piece of the frame is sent, and a
// monitor pops the queue and compares as the DUT reports each event.
module tb_decode_ctrl;

  localparam logic [17:0] M_SD = 18'b10_11_00_01_11_00_01_01_01;
  localparam logic [17:0] S_SD = 18'b10_10_10_00_11_10_00_11_10;
  localparam logic [7:0]  K_NONE = 8'd0, K_START = 8'd1, K_WORD = 8'd2,
                          K_CRC = 8'd3, K_OVER = 8'd4, K_ERR = 8'd5;

  typedef struct packed { logic [7:0] kind; logic [23:0] val; } ev_t;

  logic        clk = 1'b0;
  logic        rst, line_in;
  logic [6:0]  slave_words;
  logic        decode_over, frame_start, word_valid, crc_valid, crc_ok;
  logic        frame_over, frame_err;
  logic [1:0]  frame_type;
  logic [15:0] word_data;
  logic [6:0]  word_count;
  logic [2:0]  err_code;

  int  n_vec = 0, n_mis = 0;
  ev_t q[$];
  bit  dov_next = 0;

  decode_ctrl dut (
    .clk(clk), .rst(rst), .line_in(line_in), .slave_words(slave_words),
    .decode_over(decode_over), .frame_start(frame_start), .frame_type(frame_type),
    .word_data(word_data), .word_valid(word_valid), .word_count(word_count),
    .crc_valid(crc_valid), .crc_ok(crc_ok), .frame_over(frame_over),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] k, input logic [23:0] v);
    q.push_back({k, v});
  endtask

  task automatic see(input logic [7:0] k, input logic [23:0] v);
    ev_t e;
    e = (q.size() != 0) ? q.pop_front() : ev_t'({K_NONE, 24'd0});
    chk("event", 64'({k, v}), 64'(e));
  endtask

  // One half-bit lasts 8 clocks.
  task automatic hb(input logic v);
    line_in = v;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    hb(v); hb(~v);
  endtask

  task automatic send_sd(input logic [17:0] sd);
    for (int i = 17; i >= 0; i--) hb(sd[i]);
  endtask

  // Reference CRC-7 (x^7+x^6+x^5+x^2+1, seed 0, MSB first) plus even parity.
  function automatic logic [7:0] check_field(input logic [15:0] g [4], input int n);
    logic [6:0] c;
    logic       p, d;
    c = '0; p = 1'b0;
    for (int w = 0; w < n; w++)
      for (int b = 15; b >= 0; b--) begin
        d = g[w][b];
        p = p ^ d;
        c = (d ^ c[6]) ? ({c[5:0], 1'b0} ^ 7'h65) : {c[5:0], 1'b0};
      end
    return {c, p ^ (^c)};
  endfunction

  // Sends a frame and queues its expected events. inj_w: word whose last bit
  // is replaced by the pair 11. stop_w: stop before sending this word.
  task automatic send_frame(input bit master, input int nw, input bit flip,
                            input int inj_w, input int stop_w);
    logic [15:0] g [4];
    logic [15:0] w;
    logic [7:0]  f;
    int          gi;
    bit          live;
    live = 1; gi = 0;
    push(K_START, master ? 24'd1 : 24'd2);
    send_sd(master ? M_SD : S_SD);
    for (int i = 0; i < nw; i++) begin
      if (i == stop_w) return;
      w = master ? 16'hA5C3 : 16'(i + 1);
      if (live) begin
        if (i == inj_w) begin push(K_ERR, 24'd1); live = 0; end
        else push(K_WORD, 24'(w));
      end
      for (int b = 15; b >= 0; b--) begin
        if (i == inj_w && b == 0) begin hb(1'b1); hb(1'b1); end
        else send_bit(w[b]);
      end
      g[gi] = w; gi++;
      if (gi == 4 || i == nw - 1) begin
        f = check_field(g, gi);
        if (flip && i == 3) begin
          f = f ^ 8'h08;
          if (live) begin
`ifdef DECODE_CRC_CHECK_EN
            push(K_CRC, 24'd0); push(K_ERR, 24'd2); live = 0;
`else
            push(K_CRC, 24'd1);
`endif
          end
        end else if (live) push(K_CRC, 24'd1);
        for (int b = 7; b >= 0; b--) send_bit(f[b]);
        gi = 0;
      end
    end
    if (live) push(K_OVER, 24'd0);
    hb(1'b0); hb(1'b0);
  endtask

  task automatic wait_idle(input string tag);
    line_in = 1'b0;
    repeat (48) @(negedge clk);
    for (int i = 0; i < 300 && decode_over; i++) @(negedge clk);
    chk(tag, 64'(decode_over), 64'd0);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  // Event monitor
  initial begin : mon
    forever begin
      @(negedge clk);
      if (dov_next) begin chk("dov_drop", 64'(decode_over), 64'd0); dov_next = 0; end
      if (frame_start) begin
        see(K_START, 24'(frame_type));
        chk("dov_start", 64'(decode_over), 64'd1);
      end
      if (word_valid) see(K_WORD, 24'(word_data));
      if (crc_valid)  see(K_CRC, 24'(crc_ok));
      if (frame_over) begin
        see(K_OVER, 24'd0);
        chk("dov_over", 64'(decode_over), 64'd1);
        dov_next = 1;
      end
      if (frame_err)  see(K_ERR, 24'(err_code));
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst = 1'b0; line_in = 1'b0; slave_words = 7'd8;
    repeat (4) @(negedge clk);
    chk("reset", 64'({decode_over, frame_start, frame_type, word_data, word_valid,
                      word_count, crc_valid, crc_ok, frame_over, frame_err, err_code}), 64'd0);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // Master frame, single word
    send_frame(1'b1, 1, 1'b0, -1, -1);
    wait_idle("master_idle");
    chk("master_type", 64'(frame_type), 64'd1);

    // Slave frame, 8 words, two groups
    slave_words = 7'd8;
    send_frame(1'b0, 8, 1'b0, -1, -1);
    wait_idle("slave_idle");
    chk("wcount", 64'(word_count), 64'd8);
    chk("slave_type", 64'(frame_type), 64'd2);

    // First check field corrupted
    send_frame(1'b0, 8, 1'b1, -1, -1);
    wait_idle("crcbad_idle");

    // Manchester violation in word 2
    send_frame(1'b0, 8, 1'b0, 1, -1);
    wait_idle("manch_idle");

    // Silent line after word 1 of a 4-word frame
    slave_words = 7'd4;
    send_frame(1'b0, 4, 1'b0, -1, 1);
    push(K_ERR, 24'd4);
    repeat (40) @(negedge clk);
    wait_idle("tmo_idle");

    // Illegal slave word count
    slave_words = 7'd3;
    push(K_START, 24'd2);
    push(K_ERR, 24'd5);
    send_sd(S_SD);
    wait_idle("sw_idle");

    // Reset mid-word, then a fresh master frame
    slave_words = 7'd8;
    push(K_START, 24'd2);
    send_sd(S_SD);
    for (int i = 0; i < 8; i++) send_bit(1'(i));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid", 64'({decode_over, frame_start, frame_type, word_data, word_valid,
                        word_count, crc_valid, crc_ok, frame_over, frame_err, err_code}), 64'd0);
    rst = 1'b1;
    q.delete();
    line_in = 1'b0;
    repeat (48) @(negedge clk);
    send_frame(1'b1, 1, 1'b0, -1, -1);
    wait_idle("post_rst_idle");
    chk("post_rst_data", 64'(word_data), 64'hA5C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
